// File: rtl/rggen_rwc_command_tracker.sv
// Hardware companion for an RWC command field: captures a pending command, hands it to an
// engine over valid/ready, waits for done (or a timeout), then pulses the field's clear.
module rggen_rwc_command_tracker #(
   parameter int               WIDTH          = 8,
   parameter logic [WIDTH-1:0] INITIAL_VALUE  = '0,
   parameter int               TIMEOUT_CYCLES = 0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_value,
   output logic             o_clear,
   output logic             o_cmd_valid,
   input  logic             i_cmd_ready,
   output logic [WIDTH-1:0] o_cmd,
   input  logic             i_done,
   output logic             o_busy,
   output logic             o_timeout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      BUSY  = 2'd2,
      CLEAR = 2'd3
   } state_t;

   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   state_t state;
   logic   expire;

   // Counter only exists when a timeout is configured; it is zeroed while idle so every
   // command starts counting from 0 on its first REQ cycle.
   if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
      logic [CNT_W-1:0] count;

      always_ff @(posedge i_clk) begin
         if (!i_rst_n) begin
            count <= '0;
         end else if (state == IDLE) begin
            count <= '0;
         end else if ((state == REQ || state == BUSY) && count != CNT_MAX) begin
            count <= count + 1'b1;
         end
      end

      assign expire = (state == REQ || state == BUSY) && (count == CNT_MAX);
   end else begin : g_no_timeout
      assign expire = 1'b0;
   end

   // NOTE: reset is sampled on the clock edge, so it lives inside the clocked block and every
   // register, including the captured command, returns to a known value on that edge.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         o_cmd       <= INITIAL_VALUE;
         o_cmd_valid <= 1'b0;
         o_busy      <= 1'b0;
         o_clear     <= 1'b0;
         o_timeout   <= 1'b0;
      end else begin
         o_clear   <= 1'b0;
         o_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (i_value != INITIAL_VALUE) begin
                  state       <= REQ;
                  o_cmd       <= i_value;
                  o_cmd_valid <= 1'b1;
                  o_busy      <= 1'b1;
               end
            end
            REQ: begin
               // Progress is tested first so a handshake always beats expiry.
               if (i_cmd_ready) begin
                  state       <= BUSY;
                  o_cmd_valid <= 1'b0;
               end else if (expire) begin
                  state       <= CLEAR;
                  o_cmd_valid <= 1'b0;
                  o_clear     <= 1'b1;
                  o_timeout   <= 1'b1;
               end
            end
            BUSY: begin
               if (i_done) begin
                  state   <= CLEAR;
                  o_clear <= 1'b1;
               end else if (expire) begin
                  state     <= CLEAR;
                  o_clear   <= 1'b1;
                  o_timeout <= 1'b1;
               end
            end
            CLEAR: begin
               state  <= IDLE;
               o_busy <= 1'b0;
            end
            default: begin
               state       <= IDLE;
               o_cmd_valid <= 1'b0;
               o_busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rggen_rwc_command_tracker.sv
// Self-checking bench: three trackers (no timeout, timeout 5, timeout 4) run in lockstep against
// a transaction-level model, each fed by its own model of the RWC field.
module tb_rggen_rwc_command_tracker;
   localparam int W = 8;
   localparam int N = 3;

   logic         i_clk = 1'b0;
   logic         i_rst_n;
   logic [W-1:0] i_value     [N];
   logic         i_cmd_ready [N];
   logic         i_done      [N];
   logic         o_clear     [N];
   logic         o_cmd_valid [N];
   logic         o_busy      [N];
   logic         o_timeout   [N];
   logic [W-1:0] o_cmd       [N];

   always #5 i_clk = ~i_clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      rggen_rwc_command_tracker #(
         .WIDTH          (W),
         .INITIAL_VALUE  (8'h00),
         .TIMEOUT_CYCLES ((g == 0) ? 0 : (g == 1) ? 5 : 4)
      ) dut (
         .i_clk       (i_clk),
         .i_rst_n     (i_rst_n),
         .i_value     (i_value[g]),
         .o_clear     (o_clear[g]),
         .o_cmd_valid (o_cmd_valid[g]),
         .i_cmd_ready (i_cmd_ready[g]),
         .o_cmd       (o_cmd[g]),
         .i_done      (i_done[g]),
         .o_busy      (o_busy[g]),
         .o_timeout   (o_timeout[g])
      );
   end

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: a command is in flight (active), has been accepted or not, and has an
   // age in cycles since capture; a separate flag marks the one-cycle clear.
   bit           m_active [N];
   bit           m_acc    [N];
   bit           m_clr    [N];
   bit           m_tmo    [N];
   int           m_age    [N];
   logic [W-1:0] m_cmd    [N];

   // RWC field model: software writes win over the hardware clear.
   logic [W-1:0] field   [N];
   bit           sw_we   [N];
   logic [W-1:0] sw_data [N];

   function automatic int tmo(input int k);
      return (k == 0) ? 0 : (k == 1) ? 5 : 4;
   endfunction

   function automatic logic [W+3:0] act(input int k);
      return {o_cmd_valid[k], o_busy[k], o_clear[k], o_timeout[k], o_cmd[k]};
   endfunction

   function automatic logic [W+3:0] expv(input int k);
      return {m_active[k] && !m_acc[k], m_active[k] || m_clr[k], m_clr[k], m_clr[k] && m_tmo[k], m_cmd[k]};
   endfunction

   task automatic model_step(input int k);
      bit progress;
      bit expired;
      if (!i_rst_n) begin
         m_active[k] = 0; m_acc[k] = 0; m_clr[k] = 0; m_tmo[k] = 0; m_age[k] = 0; m_cmd[k] = '0;
      end else if (m_clr[k]) begin
         m_clr[k] = 0;
         m_tmo[k] = 0;
      end else if (!m_active[k]) begin
         if (i_value[k] != '0) begin
            m_active[k] = 1; m_acc[k] = 0; m_age[k] = 0; m_cmd[k] = i_value[k];
         end
      end else begin
         progress = m_acc[k] ? i_done[k] : i_cmd_ready[k];
         expired  = (tmo(k) > 0) && (m_age[k] >= tmo(k) - 1);
         if (progress && !m_acc[k]) begin
            m_acc[k] = 1;
         end else if (progress || expired) begin
            m_active[k] = 0;
            m_clr[k]    = 1;
            m_tmo[k]    = !progress;
         end
         m_age[k]++;
      end
   endtask

   task automatic tick();
      logic [W-1:0] nxt [N];
      @(posedge i_clk);
      for (int k = 0; k < N; k++) begin
         nxt[k] = sw_we[k] ? sw_data[k] : (m_clr[k] ? '0 : field[k]);
         model_step(k);
      end
      #1;
      for (int k = 0; k < N; k++) begin
         field[k]   = nxt[k];
         i_value[k] = nxt[k];
         sw_we[k]   = 0;
      end
      cyc++;
   endtask

   task automatic sw_write_all(input logic [W-1:0] d);
      for (int k = 0; k < N; k++) begin
         sw_we[k]   = 1;
         sw_data[k] = d;
      end
   endtask

   task automatic set_hs(input logic rdy, input logic dn);
      for (int k = 0; k < N; k++) begin
         i_cmd_ready[k] = rdy;
         i_done[k]      = dn;
      end
   endtask

   task automatic drain();
      bit idle;
      set_hs(1'b1, 1'b1);
      i_rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         idle = 1;
         for (int k = 0; k < N; k++)
            if (m_active[k] || m_clr[k] || field[k] != '0) idle = 0;
         if (idle) break;
         tick();
         for (int k = 0; k < N; k++) begin
            checks++;
            if (act(k) !== expv(k)) begin
               errors++;
               $display("FAIL drain dut%0d cyc %0d: got %h want %h", k, cyc, act(k), expv(k));
            end
         end
      end
      checks++;
      if (!idle) begin
         errors++;
         $display("FAIL drain_bound: model not idle within 40 cycles (got busy, want idle)");
      end
      set_hs(1'b0, 1'b0);
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      tick();
      tick();
      for (int k = 0; k < N; k++) begin
         checks++;
         if (act(k) !== '0) begin
            errors++;
            $display("FAIL reset dut%0d: got %h want %h", k, act(k), {(W+4){1'b0}});
         end
      end
      i_rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         for (int k = 0; k < N; k++) begin
            checks++;
            if (o_busy[k] !== 1'b0 || o_cmd_valid[k] !== 1'b0 || o_clear[k] !== 1'b0 || o_cmd[k] !== 8'h00) begin
               errors++;
               $display("FAIL idle dut%0d cyc %0d: got %h want %h", k, cyc, act(k), {(W+4){1'b0}});
            end
         end
      end
   endtask

   task automatic test_basic();
      int vcnt [N] = '{0, 0, 0};
      int ccnt [N] = '{0, 0, 0};
      set_hs(1'b1, 1'b0);
      sw_write_all(8'h5A);
      for (int i = 0; i < 8; i++) begin
         // i=0: field written, 1: captured, 2: handshake, 3..4: busy, done on busy cycle 3
         i_done[0] = (i == 5); i_done[1] = (i == 5); i_done[2] = (i == 5);
         tick();
         for (int k = 0; k < N; k++) begin
            checks++;
            if (act(k) !== expv(k)) begin
               errors++;
               $display("FAIL basic dut%0d cyc %0d: got %h want %h", k, cyc, act(k), expv(k));
            end
            if (o_cmd_valid[k] === 1'b1) begin
               vcnt[k]++;
               checks++;
               if (o_cmd[k] !== 8'h5A) begin
                  errors++;
                  $display("FAIL basic_cmd dut%0d: got %h want 5a", k, o_cmd[k]);
               end
            end
            if (o_clear[k] === 1'b1) ccnt[k]++;
         end
      end
      for (int k = 0; k < N; k++) begin
         checks++;
         if (vcnt[k] !== 1 || ccnt[k] !== 1 || o_busy[k] !== 1'b0 || i_value[k] !== 8'h00) begin
            errors++;
            $display("FAIL basic_summary dut%0d: got valid=%0d clear=%0d busy=%b value=%h want 1 1 0 00",
                     k, vcnt[k], ccnt[k], o_busy[k], i_value[k]);
         end
      end
      set_hs(1'b0, 1'b0);
   endtask

   task automatic test_backpressure();
      set_hs(1'b0, 1'b0);
      sw_write_all(8'h03);
      tick();
      tick();
      for (int i = 0; i < 7; i++) begin
         checks++;
         if (o_cmd_valid[0] !== 1'b1 || o_cmd[0] !== 8'h03) begin
            errors++;
            $display("FAIL backpressure cyc %0d: got valid=%b cmd=%h want 1 03", cyc, o_cmd_valid[0], o_cmd[0]);
         end
         if (i == 2) sw_write_all(8'h07);
         tick();
         for (int k = 0; k < N; k++) begin
            checks++;
            if (act(k) !== expv(k)) begin
               errors++;
               $display("FAIL backpressure_model dut%0d cyc %0d: got %h want %h", k, cyc, act(k), expv(k));
            end
         end
      end
      drain();
   endtask

   task automatic test_timeout();
      int  vcnt = 0;
      bit  seen = 0;
      set_hs(1'b0, 1'b0);
      sw_write_all(8'h21);
      tick();
      for (int i = 0; i < 20; i++) begin
         tick();
         for (int k = 0; k < N; k++) begin
            checks++;
            if (act(k) !== expv(k)) begin
               errors++;
               $display("FAIL timeout_model dut%0d cyc %0d: got %h want %h", k, cyc, act(k), expv(k));
            end
         end
         if (o_cmd_valid[1] === 1'b1) vcnt++;
         if (o_clear[1] === 1'b1) begin
            seen = 1;
            checks++;
            if (o_timeout[1] !== 1'b1 || vcnt !== 5) begin
               errors++;
               $display("FAIL timeout: got timeout=%b valid_cycles=%0d want 1 5", o_timeout[1], vcnt);
            end
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL timeout_bound: got no clear within 20 cycles want clear");
      end
      tick();
      checks++;
      if (o_busy[1] !== 1'b0) begin
         errors++;
         $display("FAIL timeout_idle: got busy=%b want 0", o_busy[1]);
      end
      drain();
   endtask

   task automatic test_tiebreak();
      // done lands on the expiry cycle of the timeout-4 tracker: progress wins
      set_hs(1'b1, 1'b0);
      sw_write_all(8'h44);
      tick();
      tick();
      tick();
      set_hs(1'b0, 1'b0);
      tick();
      tick();
      set_hs(1'b0, 1'b1);
      tick();
      checks++;
      if (o_clear[2] !== 1'b1 || o_timeout[2] !== 1'b0) begin
         errors++;
         $display("FAIL tiebreak_done: got clear=%b timeout=%b want 1 0", o_clear[2], o_timeout[2]);
      end
      drain();
      // handshake on the expiry cycle: enters BUSY saturated, times out next cycle
      set_hs(1'b0, 1'b0);
      sw_write_all(8'h45);
      tick();
      tick();
      tick();
      tick();
      tick();
      set_hs(1'b1, 1'b0);
      tick();
      checks++;
      if (o_busy[2] !== 1'b1 || o_cmd_valid[2] !== 1'b0 || o_clear[2] !== 1'b0) begin
         errors++;
         $display("FAIL tiebreak_hs: got %h want busy only", act(2));
      end
      set_hs(1'b0, 1'b0);
      tick();
      checks++;
      if (o_clear[2] !== 1'b1 || o_timeout[2] !== 1'b1) begin
         errors++;
         $display("FAIL tiebreak_expire: got clear=%b timeout=%b want 1 1", o_clear[2], o_timeout[2]);
      end
      for (int k = 0; k < N; k++) begin
         checks++;
         if (act(k) !== expv(k)) begin
            errors++;
            $display("FAIL tiebreak_model dut%0d cyc %0d: got %h want %h", k, cyc, act(k), expv(k));
         end
      end
      drain();
   endtask

   task automatic test_reset_busy();
      set_hs(1'b1, 1'b0);
      sw_write_all(8'h11);
      tick();
      tick();
      tick();
      set_hs(1'b0, 1'b0);
      i_rst_n = 1'b0;
      tick();
      for (int k = 0; k < N; k++) begin
         checks++;
         if (act(k) !== '0) begin
            errors++;
            $display("FAIL reset_busy dut%0d: got %h want all zero", k, act(k));
         end
      end
      i_rst_n = 1'b1;
      tick();
      for (int k = 0; k < N; k++) begin
         checks++;
         if (o_cmd[k] !== 8'h11 || o_cmd_valid[k] !== 1'b1 || o_clear[k] !== 1'b0) begin
            errors++;
            $display("FAIL reset_recapture dut%0d: got %h want valid with cmd 11", k, act(k));
         end
      end
      drain();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] seq [4] = '{8'h81, 8'h82, 8'h83, 8'h84};
      int issued = 1;
      int last   = -1;
      int pulses = 0;
      set_hs(1'b1, 1'b1);
      sw_write_all(seq[0]);
      for (int i = 0; i < 40 && pulses < 4; i++) begin
         tick();
         for (int k = 0; k < N; k++) begin
            checks++;
            if (act(k) !== expv(k)) begin
               errors++;
               $display("FAIL b2b_model dut%0d cyc %0d: got %h want %h", k, cyc, act(k), expv(k));
            end
         end
         if (o_clear[0] === 1'b1) begin
            if (last >= 0) begin
               checks++;
               if (cyc - last !== 4) begin
                  errors++;
                  $display("FAIL b2b_period: got %0d want 4", cyc - last);
               end
            end
            last = cyc;
            pulses++;
            // written during CLEAR: the field keeps the new command
            if (issued < 4) begin
               sw_write_all(seq[issued]);
               issued++;
            end
         end
      end
      checks++;
      if (pulses !== 4) begin
         errors++;
         $display("FAIL b2b_count: got %0d clears want 4", pulses);
      end
      drain();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         i_rst_n = ($urandom_range(0, 149) != 0);
         for (int k = 0; k < N; k++) begin
            i_cmd_ready[k] = ($urandom_range(0, 2) == 0);
            i_done[k]      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) begin
               sw_we[k]   = 1;
               sw_data[k] = W'($urandom_range(0, 255));
            end
         end
         tick();
         for (int k = 0; k < N; k++) begin
            checks++;
            if (act(k) !== expv(k)) begin
               errors++;
               $display("FAIL random dut%0d cyc %0d: got %h want %h", k, cyc, act(k), expv(k));
            end
         end
      end
      drain();
   endtask

   initial begin
      i_rst_n = 1'b0;
      for (int k = 0; k < N; k++) begin
         i_value[k] = '0; i_cmd_ready[k] = 0; i_done[k] = 0;
         field[k] = '0; sw_we[k] = 0; sw_data[k] = '0;
         m_active[k] = 0; m_acc[k] = 0; m_clr[k] = 0; m_tmo[k] = 0; m_age[k] = 0; m_cmd[k] = '0;
      end
      test_reset();
      test_basic();
      test_backpressure();
      test_timeout();
      test_tiebreak();
      test_reset_busy();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
